// File: rtl/flash_stream_reader_if.sv
// rtl/flash_stream_reader_if.sv - request, byte-stream and flash-engine command bundle for flash_stream_reader
interface flash_stream_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic [31:0] flash_cmd;
    logic [7:0]  flash_cmd_len;
    logic [7:0]  flash_data_len;
    logic        flash_start;
    logic [63:0] flash_data;
    logic        flash_complete;

    // Reader side: accepts requests, produces the byte stream, commands the engine
    modport master (
        input  req_valid, req_addr, req_len, out_ready, flash_data, flash_complete,
        output req_ready, out_valid, out_data, out_last, busy,
        output flash_cmd, flash_cmd_len, flash_data_len, flash_start
    );

    // Environment side: requester, consumer and flash engine
    modport slave (
        output req_valid, req_addr, req_len, out_ready, flash_data, flash_complete,
        input  req_ready, out_valid, out_data, out_last, busy,
        input  flash_cmd, flash_cmd_len, flash_data_len, flash_start
    );
endinterface

// File: rtl/flash_stream_reader.sv
// rtl/flash_stream_reader.sv - turns (addr, len) requests into 8-byte 0x03 READ bursts and a byte stream
module flash_stream_reader #(
    parameter int GUARD_CYCLES = 4096,
    parameter int WAKE_DELAY   = 3000,
    parameter int CNT_W        = 13
) (
    input  logic                    clk100,
    input  logic                    rst,
    flash_stream_reader_if.master   bus
);

    typedef enum logic [2:0] {
        S_GUARD, S_WAKE, S_WAKE_WAIT, S_WAKE_DLY, S_IDLE, S_ISSUE, S_WAIT, S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_DELAY - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [23:0]        addr_q, addr_d;
    logic [15:0]        remaining_q, remaining_d;
    logic [63:0]        chunk_q, chunk_d;
    logic [3:0]         n_q, n_d;
    logic [2:0]         idx_q, idx_d;
    logic               start_q, start_d;
    logic [31:0]        cmd_q, cmd_d;
    logic [7:0]         cmd_len_q, cmd_len_d;
    logic [7:0]         data_len_q, data_len_d;
    logic [23:0]        next_addr;

    assign next_addr = addr_q + 24'd8;

    // Next-state logic; the start pulse and command word are registered on entry to WAKE/ISSUE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        n_d         = n_q;
        idx_d       = idx_q;
        start_d     = 1'b0;
        cmd_d       = cmd_q;
        cmd_len_d   = cmd_len_q;
        data_len_d  = data_len_q;

        case (state_q)
            S_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d    = S_WAKE;
                    cnt_d      = '0;
                    start_d    = 1'b1;
                    cmd_d      = 32'hAB00_0000;
                    cmd_len_d  = 8'd8;
                    data_len_d = 8'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAKE: state_d = S_WAKE_WAIT;
            S_WAKE_WAIT: begin
                // the completion cycle itself is the first delay cycle
                if (bus.flash_complete) begin
                    state_d = S_WAKE_DLY;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAKE_DLY: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d      = bus.req_addr;
                    remaining_d = bus.req_len;
                    if (bus.req_len != 16'd0) begin
                        state_d    = S_ISSUE;
                        start_d    = 1'b1;
                        cmd_d      = {8'h03, bus.req_addr};
                        cmd_len_d  = 8'd32;
                        data_len_d = 8'd64;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.flash_complete) begin
                    chunk_d = bus.flash_data;
                    n_d     = (remaining_q >= 16'd8) ? 4'd8 : remaining_q[3:0];
                    idx_d   = 3'd0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    remaining_d = remaining_q - 16'd1;
                    idx_d       = idx_q + 3'd1;
                    if ({1'b0, idx_q} == n_q - 4'd1) begin
                        addr_d = next_addr;
                        if (remaining_q == 16'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d    = S_ISSUE;
                            start_d    = 1'b1;
                            cmd_d      = {8'h03, next_addr};
                            cmd_len_d  = 8'd32;
                            data_len_d = 8'd64;
                        end
                    end
                end
            end
            default: state_d = S_GUARD;
        endcase
    end

    // State and datapath registers with synchronous reset back into the guard wait
    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q     <= S_GUARD;
            cnt_q       <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            chunk_q     <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            start_q     <= 1'b0;
            cmd_q       <= '0;
            cmd_len_q   <= '0;
            data_len_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            start_q     <= start_d;
            cmd_q       <= cmd_d;
            cmd_len_q   <= cmd_len_d;
            data_len_q  <= data_len_d;
        end
    end

    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.out_valid      = (state_q == S_DRAIN);
    assign bus.out_data       = (state_q == S_DRAIN) ? chunk_q[{idx_q, 3'b000} +: 8] : 8'd0;
    assign bus.out_last       = (state_q == S_DRAIN) && (remaining_q == 16'd1);
    assign bus.flash_start    = start_q;
    assign bus.flash_cmd      = cmd_q;
    assign bus.flash_cmd_len  = cmd_len_q;
    assign bus.flash_data_len = data_len_q;

endmodule

// File: tb/tb_flash_stream_reader.sv
// tb/tb_flash_stream_reader.sv - scoreboard bench for flash_stream_reader with a behavioural flash engine
`timescale 1ns/1ps
module tb_flash_stream_reader;

    typedef struct packed {
        logic [31:0] cmd;
        logic [7:0]  cl;
        logic [7:0]  dl;
    } cmd_t;

    logic        clk100 = 1'b0;
    logic        rst = 1'b1;
    logic        model_complete = 1'b0;
    logic        stray_complete = 1'b0;
    logic [63:0] model_data = 64'hDEAD_BEEF_CAFE_F00D;
    logic        stall = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int popped   = 0;

    cmd_t       exp_cmd_q[$];
    logic [8:0] exp_byte_q[$];

    flash_stream_reader_if bus ();

    assign bus.flash_complete = model_complete | stray_complete;
    assign bus.flash_data     = model_data;

    flash_stream_reader dut (
        .clk100 (clk100),
        .rst    (rst),
        .bus    (bus.master)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // consumer ready: always high, or coin-flip while stalling
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk100);
            #1;
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // stream monitor: scoreboard pop and stall stability
    initial begin : monitor
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk100);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_data", 64'(bus.out_data), 64'(prev_data));
                    check("stall_last", 64'(bus.out_last), 64'(prev_last));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_byte_q.size() == 0) begin
                        check("unexpected_byte", 64'(exp_byte_q.size()), 64'd1);
                    end else begin
                        e = exp_byte_q.pop_front();
                        check("out_data", 64'(bus.out_data), 64'(e[7:0]));
                        check("out_last", 64'(bus.out_last), 64'(e[8]));
                        popped++;
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
            end
        end
    end

    // flash engine model: byte i of a read at address a is (a+i) mod 256
    initial begin : flash_model
        logic [63:0] d;
        logic [23:0] a;
        cmd_t        e;
        forever begin
            @(negedge clk100);
            if (!rst && bus.flash_start) begin
                n_starts++;
                check("start_during_drain", 64'(bus.out_valid), 64'd0);
                if (exp_cmd_q.size() == 0) begin
                    check("unexpected_start", 64'(exp_cmd_q.size()), 64'd1);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("flash_cmd", 64'(bus.flash_cmd), 64'(e.cmd));
                    check("flash_cmd_len", 64'(bus.flash_cmd_len), 64'(e.cl));
                    check("flash_data_len", 64'(bus.flash_data_len), 64'(e.dl));
                end
                a = bus.flash_cmd[23:0];
                for (int i = 0; i < 8; i++) d[8*i +: 8] = a[7:0] + 8'(i);
                if (bus.flash_cmd[31:24] == 8'hAB) d = 64'd0;
                @(negedge clk100);
                if (!rst) check("start_pulse_width", 64'(bus.flash_start), 64'd0);
                @(posedge clk100);
                #1;
                model_data     = d;
                model_complete = 1'b1;
                @(posedge clk100);
                #1;
                model_complete = 1'b0;
                model_data     = 64'hDEAD_BEEF_CAFE_F00D;
            end
        end
    end

    task automatic push_request(input logic [23:0] addr, input int len);
        cmd_t c;
        for (int k = 0; k < (len + 7) / 8; k++) begin
            c.cmd = {8'h03, addr + 24'(8 * k)};
            c.cl  = 8'd32;
            c.dl  = 8'd64;
            exp_cmd_q.push_back(c);
        end
        for (int k = 0; k < len; k++)
            exp_byte_q.push_back({(k == len - 1), 8'(addr + 24'(k))});
    endtask

    // drive one request at a negedge once req_ready is seen; returns after acceptance edge
    task automatic send_request(input logic [23:0] addr, input int len);
        int w;
        w = 0;
        while (!bus.req_ready && w < 100) begin
            @(negedge clk100);
            w++;
        end
        check("req_ready_before_req", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = 16'(len);
        @(posedge clk100);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk100);
        check("start_latency", 64'(bus.flash_start), 64'(len != 0));
        check("busy_after_accept", 64'(bus.busy), 64'(len != 0));
    endtask

    task automatic do_req(input logic [23:0] addr, input int len, input logic stall_en);
        int w;
        int s0;
        s0    = n_starts;
        stall = stall_en;
        push_request(addr, len);
        send_request(addr, len);
        if (len == 0) begin
            repeat (20) begin
                @(negedge clk100);
                check("zero_len_ready", 64'(bus.req_ready), 64'd1);
                check("zero_len_valid", 64'(bus.out_valid), 64'd0);
            end
        end else begin
            w = 0;
            while (!(bus.req_ready && exp_byte_q.size() == 0) && w < 3000) begin
                @(negedge clk100);
                w++;
            end
            check("bytes_left", 64'(exp_byte_q.size()), 64'd0);
            check("req_ready_after", 64'(bus.req_ready), 64'd1);
            check("busy_after", 64'(bus.busy), 64'd0);
        end
        check("cmds_left", 64'(exp_cmd_q.size()), 64'd0);
        check("n_transactions", 64'(n_starts - s0), 64'((len + 7) / 8));
        stall = 1'b0;
    endtask

    // one-cycle reset, reset values, guard length, wake command and wake delay
    task automatic do_reset(input int stray_at);
        int   cycles;
        int   w;
        cmd_t c;
        @(posedge clk100);
        #1;
        rst = 1'b1;
        exp_byte_q.delete();
        exp_cmd_q.delete();
        c.cmd = 32'hAB00_0000;
        c.cl  = 8'd8;
        c.dl  = 8'd0;
        exp_cmd_q.push_back(c);
        @(posedge clk100);
        #1;
        rst = 1'b0;
        @(negedge clk100);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_flash_start", 64'(bus.flash_start), 64'd0);
        check("rst_flash_cmd", 64'(bus.flash_cmd), 64'd0);
        check("rst_cmd_len", 64'(bus.flash_cmd_len), 64'd0);
        check("rst_data_len", 64'(bus.flash_data_len), 64'd0);
        cycles = 0;
        while (!bus.flash_start && cycles < 5000) begin
            stray_complete = (cycles == stray_at);
            cycles++;
            @(negedge clk100);
        end
        stray_complete = 1'b0;
        check("guard_cycles", 64'(cycles), 64'd4096);
        w = 0;
        while (!bus.flash_complete && w < 50) begin
            @(negedge clk100);
            w++;
        end
        check("wake_complete_seen", 64'(bus.flash_complete), 64'd1);
        cycles = 0;
        do begin
            @(negedge clk100);
            cycles++;
        end while (!bus.req_ready && cycles < 4000);
        check("wake_delay", 64'(cycles), 64'd3000);
        check("wake_cmds_left", 64'(exp_cmd_q.size()), 64'd0);
    endtask

    initial begin
        int w;
        int p0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 24'd0;
        bus.req_len   = 16'd0;

        do_reset(-1);
        do_req(24'h000100, 3, 1'b0);
        do_req(24'hFFFFFC, 10, 1'b0);
        do_req(24'h001234, 20, 1'b1);
        do_req(24'h000050, 0, 1'b0);

        // reset in the middle of a stalled drain
        stall = 1'b1;
        p0 = popped;
        push_request(24'h000400, 20);
        send_request(24'h000400, 20);
        w = 0;
        while (!(popped >= p0 + 3 && bus.out_valid) && w < 500) begin
            @(negedge clk100);
            w++;
        end
        check("mid_drain_reached", 64'(bus.out_valid), 64'd1);
        stall = 1'b0;
        do_reset(100);
        do_req(24'h000100, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
